// File: rtl/uart2wifi_reg_arbiter.sv
// rtl/uart2wifi_reg_arbiter.sv - round-robin arbiter sharing one register bus between a UART port and a WiFi port
module uart2wifi_reg_arbiter #(
   parameter int ADDR_W   = 2,
   parameter int DATA_W   = 32,
   parameter int NUM_REGS = 3
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              a_req_i,
   input  logic              a_we_i,
   input  logic [ADDR_W-1:0] a_addr_i,
   input  logic [DATA_W-1:0] a_wdata_i,
   output logic              a_gnt_o,
   output logic              a_err_o,
   output logic              a_rvalid_o,
   output logic [DATA_W-1:0] a_rdata_o,
   input  logic              b_req_i,
   input  logic              b_we_i,
   input  logic [ADDR_W-1:0] b_addr_i,
   input  logic [DATA_W-1:0] b_wdata_i,
   output logic              b_gnt_o,
   output logic              b_err_o,
   output logic              b_rvalid_o,
   output logic [DATA_W-1:0] b_rdata_o,
   output logic [ADDR_W-1:0] reg_addr_o,
   output logic [DATA_W-1:0] reg_wdata_o,
   output logic              reg_write_o,
   output logic              reg_read_o,
   input  logic [DATA_W-1:0] reg_rdata_i
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

   localparam logic [31:0] NUM_REGS_U = NUM_REGS;

   state_t              state_q;
   logic                last_b_q;
   logic                sel_b_q;
   logic                a_gnt_q, a_err_q, a_rvalid_q;
   logic                b_gnt_q, b_err_q, b_rvalid_q;
   logic [DATA_W-1:0]   a_rdata_q, b_rdata_q;
   logic [ADDR_W-1:0]   reg_addr_q;
   logic [DATA_W-1:0]   reg_wdata_q;
   logic                reg_write_q, reg_read_q;

   logic                sel_a_d, sel_b_d;
   logic                req_we_d;
   logic [ADDR_W-1:0]   req_addr_d;
   logic [DATA_W-1:0]   req_wdata_d;
   logic                legal_d;

   // A wins a tie only when B was served last.
   assign sel_a_d     = a_req_i & (~b_req_i | last_b_q);
   assign sel_b_d     = b_req_i & ~sel_a_d;
   assign req_we_d    = sel_a_d ? a_we_i    : b_we_i;
   assign req_addr_d  = sel_a_d ? a_addr_i  : b_addr_i;
   assign req_wdata_d = sel_a_d ? a_wdata_i : b_wdata_i;
   assign legal_d     = 32'(req_addr_d) < NUM_REGS_U;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         last_b_q    <= 1'b1;
         sel_b_q     <= 1'b0;
         a_gnt_q     <= 1'b0;
         a_err_q     <= 1'b0;
         a_rvalid_q  <= 1'b0;
         b_gnt_q     <= 1'b0;
         b_err_q     <= 1'b0;
         b_rvalid_q  <= 1'b0;
         a_rdata_q   <= '0;
         b_rdata_q   <= '0;
         reg_addr_q  <= '0;
         reg_wdata_q <= '0;
         reg_write_q <= 1'b0;
         reg_read_q  <= 1'b0;
      end else begin
         a_gnt_q     <= 1'b0;
         a_err_q     <= 1'b0;
         a_rvalid_q  <= 1'b0;
         b_gnt_q     <= 1'b0;
         b_err_q     <= 1'b0;
         b_rvalid_q  <= 1'b0;
         reg_write_q <= 1'b0;
         reg_read_q  <= 1'b0;
         case (state_q)
            IDLE: begin
               if (sel_a_d | sel_b_d) begin
                  last_b_q <= sel_b_d;
                  sel_b_q  <= sel_b_d;
                  a_gnt_q  <= sel_a_d;
                  b_gnt_q  <= sel_b_d;
                  // Error grants still pass through ISSUE so the held request is not resampled.
                  state_q  <= ISSUE;
                  if (!legal_d) begin
                     a_err_q <= sel_a_d;
                     b_err_q <= sel_b_d;
                  end else begin
                     reg_addr_q <= req_addr_d;
                     if (req_we_d) begin
                        reg_write_q <= 1'b1;
                        reg_wdata_q <= req_wdata_d;
                     end else begin
                        reg_read_q  <= 1'b1;
                        reg_wdata_q <= '0;
                     end
                  end
               end
            end
            ISSUE: begin
               state_q <= reg_read_q ? WAIT : IDLE;
            end
            WAIT: begin
               if (sel_b_q) begin
                  b_rdata_q  <= reg_rdata_i;
                  b_rvalid_q <= 1'b1;
               end else begin
                  a_rdata_q  <= reg_rdata_i;
                  a_rvalid_q <= 1'b1;
               end
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign a_gnt_o     = a_gnt_q;
   assign a_err_o     = a_err_q;
   assign a_rvalid_o  = a_rvalid_q;
   assign a_rdata_o   = a_rdata_q;
   assign b_gnt_o     = b_gnt_q;
   assign b_err_o     = b_err_q;
   assign b_rvalid_o  = b_rvalid_q;
   assign b_rdata_o   = b_rdata_q;
   assign reg_addr_o  = reg_addr_q;
   assign reg_wdata_o = reg_wdata_q;
   assign reg_write_o = reg_write_q;
   assign reg_read_o  = reg_read_q;

endmodule

// File: doc/uart2wifi_reg_arbiter.md
# uart2wifi_reg_arbiter

Two-port arbiter that shares the single uart2wifi_core_sram register bus between two requesters: port A (UART command path) and port B (WiFi host path). It accepts one request at a time with round-robin fairness, sequences the register write or read cycle, and returns read data to the winning requester. Out-of-range addresses are rejected without touching the register bus.

## Interface
Parameters:
- ADDR_W, 2, width of register address on all ports
- DATA_W, 32, width of register data
- NUM_REGS, 3, number of implemented registers; legal addresses 0..NUM_REGS-1

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  reset, asynchronous and active-high
- a_req  in  1  port A request, held until a_gnt seen high
- a_we  in  1  port A 1=write, 0=read; stable while a_req high
- a_addr  in  ADDR_W  port A register address
- a_wdata  in  DATA_W  port A write data
- a_gnt  out  1  one-cycle pulse: port A request accepted (also on error)
- a_err  out  1  one-cycle pulse with a_gnt: address out of range
- a_rvalid  out  1  one-cycle pulse: a_rdata holds read result
- a_rdata  out  DATA_W  port A read data, held until next port A read
- b_req, b_we, b_addr, b_wdata, b_gnt, b_err, b_rvalid, b_rdata  identical to port A, for port B
- reg_addr  out  ADDR_W  register bus address
- reg_wdata  out  DATA_W  register bus write data
- reg_write  out  1  register bus write strobe
- reg_read  out  1  register bus read strobe
- reg_rdata  in  DATA_W  register bus read data, valid the cycle after reg_read

## Operation
- States: IDLE, ISSUE, WAIT.
- IDLE: sample a_req/b_req each cycle. Winner's we/addr/wdata latched at the clock edge.
  - Only one req high -> grant it.
  - Both high -> grant the port not served last (last-served pointer). Pointer resets to B, so A wins the first contention.
  - Pointer updates to the granted port on every grant, including error grants.
- Address check: addr >= NUM_REGS -> x_gnt and x_err pulse, no reg_write/reg_read, next state IDLE, pointer updates, x_rdata unchanged, no rvalid.
- ISSUE (legal address): drive reg_addr = latched addr. Write: reg_write=1, reg_wdata = latched data, next IDLE. Read: reg_read=1, reg_wdata=0, next WAIT. x_gnt pulses in this cycle.
- WAIT: capture reg_rdata into winner's x_rdata at the end of the cycle, next IDLE. x_rvalid pulses the following cycle.
- Requests arriving while not in IDLE are held by the requester; no queueing inside the block.
- reg_write and reg_read are never high together. At most one of a_gnt/b_gnt is high in any cycle.
- Reset, including mid-transaction: all state and outputs return to reset values immediately. An in-flight transaction is dropped without gnt/rvalid, and the requester reissues it.

## Timing
- Reset values: a_gnt, b_gnt, a_err, b_err, a_rvalid, b_rvalid, reg_write, reg_read = 0. a_rdata, b_rdata, reg_addr, reg_wdata = 0. State IDLE, pointer = B.
- All outputs are registered. There is no combinational path from any input to any output.
- Request sampled in IDLE at cycle N:
  - Write: gnt and reg_write in N+1, IDLE in N+2. The next request can be sampled in N+2, so back-to-back writes complete every 2 cycles.
  - Read: gnt and reg_read in N+1, WAIT in N+2 (reg_rdata valid), rvalid with x_rdata in N+3. The next request can be sampled in N+3.
  - Error: gnt and err in N+1, IDLE in N+2.
- Requester may drop or change req the cycle after it sees gnt. If req is still high in the IDLE cycle after gnt, it is treated as a new request.
- reg_addr and reg_wdata hold their last values outside strobe cycles. Only the strobes qualify them.

## Test plan
- Reset then A writes 0xDEADBEEF to addr 1 -> reg_write=1, reg_addr=1, reg_wdata=0xDEADBEEF and a_gnt in the cycle after sampling, one strobe cycle only. B outputs stay 0.
- A reads addr 1 after that write -> reg_read one cycle, a_rvalid two cycles later with a_rdata=0xDEADBEEF. b_rvalid stays 0.
- A and B both request continuously (A writes addr 0, B writes addr 2) -> grants alternate A, B, A, B starting with A. Each grant is 2 cycles apart, with no missed or doubled grants.
- B reads addr 3 with NUM_REGS=3 -> b_gnt and b_err pulse together, no reg_read, b_rvalid stays 0, b_rdata unchanged. A pending A request is granted next.
- Assert rst during WAIT of an A read -> all outputs 0 immediately, a_rvalid never pulses. After reset release, A reissues the read and completes normally.
- Random write/readback of addrs 0..2 from both ports, two passes -> every read returns the last value written to that address by either port.
